// File: rtl/count_uart_reporter.sv
// Snapshots the free-running sample counter at a power-of-two interval and reports it
// over an 8N1 UART as 8 hex digits + CR LF, plus an "R\r\n" marker when the counter's reset flag rises.
module count_uart_reporter #(
  parameter int CLK_HZ    = 48000000,
  parameter int BAUD      = 115200,
  parameter int TRIG_BITS = 24
) (
  input  logic        clock48,
  input  logic        rst,
  input  logic [31:0] counts,
  input  logic        inited,
  input  logic        reseted,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  dropped,
  output logic [31:0] last_sent
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_TOP = CW'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [3:0]    r_byte;
  logic [7:0]    r_shift;
  logic          r_marker;
  logic          r_marker_pending;
  logic          r_reseted_d;
  logic [31:0]   r_snap;
  logic          r_tx;
  logic          r_busy;
  logic [7:0]    r_dropped;
  logic [31:0]   r_last_sent;

  logic       w_trig;
  logic       w_rise;
  logic [3:0] w_last_byte;
  logic [7:0] w_cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] frame_byte(input logic marker, input logic [3:0] idx,
                                            input logic [31:0] snap);
    logic [7:0]  b;
    logic [31:0] sh;
    b  = 8'h0A;
    sh = snap << {idx[2:0], 2'b00};
    if (marker) begin
      case (idx)
        4'd0:    b = 8'h52;
        4'd1:    b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end else if (idx < 4'd8) begin
      b = hex_ascii(sh[31:28]);
    end else if (idx == 4'd8) begin
      b = 8'h0D;
    end
    return b;
  endfunction

  assign w_trig      = inited && (counts[TRIG_BITS-1:0] == '0) && (counts != '0);
  assign w_rise      = reseted && !r_reseted_d;
  assign w_last_byte = r_marker ? 4'd2 : 4'd9;
  assign w_cur_byte  = frame_byte(r_marker, r_byte, r_snap);

  always_ff @(posedge clock48) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_baud           <= '0;
      r_bit            <= '0;
      r_byte           <= '0;
      r_shift          <= '0;
      r_marker         <= 1'b0;
      r_marker_pending <= 1'b0;
      r_reseted_d      <= 1'b0;
      r_snap           <= '0;
      r_tx             <= 1'b1;
      r_busy           <= 1'b0;
      r_dropped        <= '0;
      r_last_sent      <= '0;
    end else begin
      r_reseted_d <= reseted;

      // A trigger is lost whenever it cannot start a count frame this cycle.
      if (w_trig && (r_state != S_IDLE || r_marker_pending) && r_dropped != 8'hFF)
        r_dropped <= r_dropped + 8'd1;

      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (r_marker_pending || w_trig) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_baud  <= BAUD_TOP;
            r_byte  <= '0;
            if (r_marker_pending) begin
              r_marker         <= 1'b1;
              r_marker_pending <= 1'b0;
            end else begin
              r_marker <= 1'b0;
              r_snap   <= counts;
            end
          end
        end
        S_START: begin
          if (r_baud == '0) begin
            r_state <= S_DATA;
            r_baud  <= BAUD_TOP;
            r_bit   <= '0;
            r_shift <= w_cur_byte;
            r_tx    <= w_cur_byte[0];
          end else begin
            r_baud <= r_baud - CW'(1);
          end
        end
        S_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_TOP;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - CW'(1);
          end
        end
        S_STOP: begin
          if (r_baud == '0) begin
            if (r_byte == w_last_byte) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_START;
              r_byte  <= r_byte + 4'd1;
              r_baud  <= BAUD_TOP;
              r_tx    <= 1'b0;
            end
          end else begin
            r_baud <= r_baud - CW'(1);
          end
        end
        S_DONE: begin
          if (!r_marker) r_last_sent <= r_snap;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // A fresh rising edge always wins over the clear at marker start.
      if (w_rise) r_marker_pending <= 1'b1;
    end
  end

  assign uart_tx   = r_tx;
  assign busy      = r_busy;
  assign dropped   = r_dropped;
  assign last_sent = r_last_sent;

endmodule
